// File: rtl/brlite_tx_queue_pkg.sv
// Shared types for the BrLite transmit queue: MMR map, FSM states and the
// message format presented to the router local port.
package DMNIPkg;

    typedef enum logic [3:0] {
        BRQ_SERVICE    = 4'd0,
        BRQ_KSVC       = 4'd1,
        BRQ_TARGET     = 4'd2,
        BRQ_PRODUCER   = 4'd3,
        BRQ_PAYLOAD    = 4'd4,
        BRQ_PUSH       = 4'd5,
        BRQ_FLUSH      = 4'd6,
        BRQ_STATUS     = 4'd7,
        BRQ_IRQ_STATUS = 4'd8,
        BRQ_IRQ_EN     = 4'd9,
        BRQ_DEPTH      = 4'd10
    } brq_mmr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } brq_state_t;

    typedef struct packed {
        logic [1:0]  service;
        logic [7:0]  ksvc;
        logic [15:0] seq_target;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_out_t;

endpackage

// File: rtl/brlite_tx_queue_fifo.sv
// Message FIFO for the BrLite transmit queue: storage, pointers, occupancy,
// plus a flush that can optionally keep the in-flight head entry.
module brq_fifo
    import DMNIPkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             keep_head_i,
    input  brlite_out_t      data_i,
    output brlite_out_t      data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    brlite_out_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_next;

    assign w_rd_next = r_rd_ptr + PTR_W'(1);
    assign data_o    = r_mem[r_rd_ptr];
    assign count_o   = r_count;
    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= data_i;
            end
            if (flush_i) begin
                // Keeping the head leaves exactly the entry at rd_ptr, unless
                // it is acked in this very cycle, in which case nothing remains.
                if (keep_head_i) begin
                    r_wr_ptr <= w_rd_next;
                    if (pop_i) begin
                        r_rd_ptr <= w_rd_next;
                        r_count  <= '0;
                    end else begin
                        r_count  <= CNT_W'(1);
                    end
                end else begin
                    r_wr_ptr <= r_rd_ptr;
                    r_count  <= '0;
                end
            end else begin
                if (push_i) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (pop_i) begin
                    r_rd_ptr <= w_rd_next;
                end
                case ({push_i, pop_i})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/brlite_tx_queue.sv
// BrLite transmit queue: CPU-staged messages are pushed into a FIFO and
// drained to the router with a req/ack handshake; status, flush and IRQs.
module brlite_tx_queue
    import DMNIPkg::*;
#(
    parameter int unsigned BR_TXQ_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_en_i,
    input  logic        cfg_we_i,
    input  brq_mmr_t    cfg_addr_i,
    input  logic [31:0] cfg_data_i,
    output logic [31:0] cfg_data_o,
    output logic        irq_o,
    input  logic        br_local_busy_i,
    output logic        br_req_o,
    input  logic        br_ack_i,
    output brlite_out_t br_data_o
);

    localparam int unsigned CNT_W = $clog2(BR_TXQ_DEPTH) + 1;

    brlite_out_t      r_stage;
    brq_state_t       r_state;
    logic             r_req;
    logic             r_ovf;
    logic             r_drained;
    logic [1:0]       r_irq_en;

    logic             w_wr;
    logic             w_push_req;
    logic             w_push_ok;
    logic             w_flush;
    logic             w_pop;
    logic             w_set_ovf;
    logic             w_set_drained;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;

    assign w_wr          = cfg_en_i && cfg_we_i;
    assign w_push_req    = w_wr && (cfg_addr_i == BRQ_PUSH) && cfg_data_i[0];
    assign w_flush       = w_wr && (cfg_addr_i == BRQ_FLUSH) && cfg_data_i[0];
    // Full is judged before any same-cycle pop, so a push on full always loses.
    assign w_push_ok     = w_push_req && !w_full && !w_flush;
    assign w_set_ovf     = w_push_req && !w_flush && w_full;
    assign w_pop         = r_req && br_ack_i;
    assign w_set_drained = w_pop && (w_count == CNT_W'(1)) && !w_push_ok;

    brq_fifo #(
        .DEPTH (BR_TXQ_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push_ok),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .keep_head_i (r_state == REQ),
        .data_i      (r_stage),
        .data_o      (br_data_o),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage <= '0;
        end else if (w_wr) begin
            case (cfg_addr_i)
                BRQ_SERVICE:  r_stage.service    <= cfg_data_i[1:0];
                BRQ_KSVC:     r_stage.ksvc       <= cfg_data_i[7:0];
                BRQ_TARGET:   r_stage.seq_target <= cfg_data_i[15:0];
                BRQ_PRODUCER: r_stage.producer   <= cfg_data_i[15:0];
                BRQ_PAYLOAD:  r_stage.payload    <= cfg_data_i;
                default:      r_stage            <= r_stage;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && !br_local_busy_i && !w_flush) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (br_ack_i) begin
                        r_state <= GAP;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf     <= 1'b0;
            r_drained <= 1'b0;
            r_irq_en  <= '0;
        end else begin
            if (w_set_drained) begin
                r_drained <= 1'b1;
            end else if (w_wr && (cfg_addr_i == BRQ_IRQ_STATUS) && cfg_data_i[0]) begin
                r_drained <= 1'b0;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (cfg_addr_i == BRQ_IRQ_STATUS) && cfg_data_i[1]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (cfg_addr_i == BRQ_IRQ_EN)) begin
                r_irq_en <= cfg_data_i[1:0];
            end
        end
    end

    assign br_req_o = r_req;
    assign irq_o    = (r_irq_en[0] & r_drained) | (r_irq_en[1] & r_ovf);

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            BRQ_STATUS:     cfg_data_o = {16'd0, 8'(w_count), 4'd0, r_state, w_full, w_empty};
            BRQ_IRQ_STATUS: cfg_data_o = {30'd0, r_ovf, r_drained};
            BRQ_IRQ_EN:     cfg_data_o = {30'd0, r_irq_en};
            BRQ_DEPTH:      cfg_data_o = 32'(BR_TXQ_DEPTH);
            default:        cfg_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_brlite_tx_queue.sv
// Directed self-checking bench for brlite_tx_queue (DEPTH=4).
module tb_brlite_tx_queue;
    import DMNIPkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b0;
    logic        cfg_we_i = 1'b0;
    brq_mmr_t    cfg_addr_i = BRQ_SERVICE;
    logic [31:0] cfg_data_i = '0;
    logic [31:0] cfg_data_o;
    logic        irq_o;
    logic        br_local_busy_i = 1'b0;
    logic        br_req_o;
    logic        br_ack_i = 1'b0;
    brlite_out_t br_data_o;

    int total = 0;
    int bad   = 0;

    brlite_tx_queue #(
        .BR_TXQ_DEPTH (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_data_o      (cfg_data_o),
        .irq_o           (irq_o),
        .br_local_busy_i (br_local_busy_i),
        .br_req_o        (br_req_o),
        .br_ack_i        (br_ack_i),
        .br_data_o       (br_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mmr_wr(input brq_mmr_t a, input logic [31:0] d);
        cfg_en_i   = 1'b1;
        cfg_we_i   = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        tick();
        cfg_en_i   = 1'b0;
        cfg_we_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        br_ack_i = 1'b0;
        br_local_busy_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (br_req_o === 1'b1) break;
            tick();
        end
        total++;
        if (br_req_o !== 1'b1) begin
            bad++;
            $display("FAIL %s req timeout: got=%b want=1", tag, br_req_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", br_req_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_o); end
        total++; if (br_data_o !== brlite_out_t'(0)) begin bad++; $display("FAIL reset_data got=%h want=0", br_data_o); end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0001) begin bad++; $display("FAIL reset_status got=%h want=00000001", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0) begin bad++; $display("FAIL reset_irqstat got=%h want=0", cfg_data_o); end
        tick();
        cfg_addr_i = BRQ_IRQ_EN; #1;
        total++; if (cfg_data_o !== 32'h0) begin bad++; $display("FAIL reset_irqen got=%h want=0", cfg_data_o); end
        cfg_addr_i = BRQ_DEPTH; #1;
        total++; if (cfg_data_o !== 32'd4) begin bad++; $display("FAIL depth got=%h want=4", cfg_data_o); end
        cfg_addr_i = BRQ_PUSH; #1;
        total++; if (cfg_data_o !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", cfg_data_o); end
    endtask

    task automatic test_single();
        brlite_out_t exp;
        exp = '{service: 2'd0, ksvc: 8'h21, seq_target: 16'h0102,
                producer: 16'h0304, payload: 32'hDEADBEEF};
        do_reset();
        mmr_wr(BRQ_KSVC, 32'h21);
        mmr_wr(BRQ_TARGET, 32'h0102);
        mmr_wr(BRQ_PRODUCER, 32'h0304);
        mmr_wr(BRQ_PAYLOAD, 32'hDEADBEEF);
        mmr_wr(BRQ_PUSH, 32'h1);
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL single_req_early got=%b want=0", br_req_o); end
        tick();
        total++; if (br_req_o !== 1'b1) begin bad++; $display("FAIL single_req_rise got=%b want=1", br_req_o); end
        total++; if (br_data_o !== exp) begin bad++; $display("FAIL single_data got=%h want=%h", br_data_o, exp); end
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL single_req_drop got=%b want=0", br_req_o); end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0009) begin bad++; $display("FAIL single_status got=%h want=00000009", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h1) begin bad++; $display("FAIL single_drained got=%h want=1", cfg_data_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL single_irq_masked got=%b want=0", irq_o); end
        mmr_wr(BRQ_IRQ_EN, 32'h1);
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL single_irq_on got=%b want=1", irq_o); end
        cfg_addr_i = BRQ_IRQ_EN; #1;
        total++; if (cfg_data_o !== 32'h1) begin bad++; $display("FAIL single_irqen_rd got=%h want=1", cfg_data_o); end
        mmr_wr(BRQ_IRQ_STATUS, 32'h1);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL single_irq_clr got=%b want=0", irq_o); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        br_local_busy_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            mmr_wr(BRQ_PAYLOAD, 32'(i));
            mmr_wr(BRQ_PUSH, 32'h1);
        end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0402) begin bad++; $display("FAIL fill_status got=%h want=00000402", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h2) begin bad++; $display("FAIL fill_ovf got=%h want=2", cfg_data_o); end
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL fill_busy_req got=%b want=0", br_req_o); end
        br_local_busy_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_req("fill_drain");
            total++; if (br_data_o.payload !== 32'(k)) begin bad++; $display("FAIL fill_order got=%h want=%h", br_data_o.payload, 32'(k)); end
            br_ack_i = 1'b1;
            tick();
            br_ack_i = 1'b0;
            total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL fill_gap got=%b want=0", br_req_o); end
        end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0009) begin bad++; $display("FAIL fill_empty got=%h want=00000009", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h3) begin bad++; $display("FAIL fill_flags got=%h want=3", cfg_data_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        br_local_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) mmr_wr(BRQ_PUSH, 32'h1);
        br_local_busy_i = 1'b0;
        tick();
        total++; if (br_req_o !== 1'b1) begin bad++; $display("FAIL sim_req got=%b want=1", br_req_o); end
        cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = BRQ_PUSH; cfg_data_i = 32'h1; br_ack_i = 1'b1;
        tick();
        cfg_en_i = 1'b0; cfg_we_i = 1'b0; br_ack_i = 1'b0;
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0308) begin bad++; $display("FAIL sim_full_status got=%h want=00000308", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h2) begin bad++; $display("FAIL sim_full_ovf got=%h want=2", cfg_data_o); end
        wait_req("sim_3");
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        wait_req("sim_2");
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0204) begin bad++; $display("FAIL sim_two_status got=%h want=00000204", cfg_data_o); end
        cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = BRQ_PUSH; cfg_data_i = 32'h1; br_ack_i = 1'b1;
        tick();
        cfg_en_i = 1'b0; cfg_we_i = 1'b0; br_ack_i = 1'b0;
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0208) begin bad++; $display("FAIL sim_pushpop_status got=%h want=00000208", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h2) begin bad++; $display("FAIL sim_pushpop_flags got=%h want=2", cfg_data_o); end
    endtask

    task automatic test_flush();
        do_reset();
        br_local_busy_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mmr_wr(BRQ_PAYLOAD, 32'hF0 + 32'(i));
            mmr_wr(BRQ_PUSH, 32'h1);
        end
        br_local_busy_i = 1'b0;
        tick();
        total++; if (br_req_o !== 1'b1) begin bad++; $display("FAIL flush_req got=%b want=1", br_req_o); end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0304) begin bad++; $display("FAIL flush_pre_status got=%h want=00000304", cfg_data_o); end
        mmr_wr(BRQ_FLUSH, 32'h1);
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0104) begin bad++; $display("FAIL flush_keep_status got=%h want=00000104", cfg_data_o); end
        total++; if (br_req_o !== 1'b1) begin bad++; $display("FAIL flush_req_held got=%b want=1", br_req_o); end
        total++; if (br_data_o.payload !== 32'hF1) begin bad++; $display("FAIL flush_head got=%h want=000000f1", br_data_o.payload); end
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0009) begin bad++; $display("FAIL flush_post_status got=%h want=00000009", cfg_data_o); end
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h1) begin bad++; $display("FAIL flush_drained got=%h want=1", cfg_data_o); end
        for (int n = 0; n < 6; n++) begin
            tick();
            total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL flush_no_req got=%b want=0", br_req_o); end
        end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0001) begin bad++; $display("FAIL flush_idle_status got=%h want=00000001", cfg_data_o); end
    endtask

    task automatic test_w1c_race();
        do_reset();
        mmr_wr(BRQ_IRQ_EN, 32'h1);
        mmr_wr(BRQ_PUSH, 32'h1);
        wait_req("w1c");
        cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = BRQ_IRQ_STATUS; cfg_data_i = 32'h1; br_ack_i = 1'b1;
        tick();
        cfg_en_i = 1'b0; cfg_we_i = 1'b0; br_ack_i = 1'b0;
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h1) begin bad++; $display("FAIL w1c_race got=%h want=1", cfg_data_o); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL w1c_irq got=%b want=1", irq_o); end
        mmr_wr(BRQ_IRQ_STATUS, 32'h1);
        cfg_addr_i = BRQ_IRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h want=0", cfg_data_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL w1c_irq_fall got=%b want=0", irq_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mmr_wr(BRQ_PAYLOAD, 32'h55);
        mmr_wr(BRQ_PUSH, 32'h1);
        wait_req("rstmid");
        rst_i = 1'b1;
        tick();
        total++; if (br_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b want=0", br_req_o); end
        cfg_addr_i = BRQ_STATUS; #1;
        total++; if (cfg_data_o !== 32'h0000_0001) begin bad++; $display("FAIL rstmid_status got=%h want=00000001", cfg_data_o); end
        total++; if (br_data_o !== brlite_out_t'(0)) begin bad++; $display("FAIL rstmid_data got=%h want=0", br_data_o); end
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_simultaneous();
        test_flush();
        test_w1c_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brlite_tx_queue.md
Name: brlite_tx_queue

Overview:
- Parametrised successor to the single-slot BrLite send path in the network-interface MMR block.
- The CPU stages a full BrLite message in MMRs, then pushes it into a FIFO of BR_TXQ_DEPTH entries. The queue drains the FIFO to the BrLite router with a req/ack handshake.
- Adds behaviour the single-slot path lacks: occupancy/status readback, a sticky overflow flag, flush, and a maskable "queue drained" interrupt.
- Sits between the CPU MMR decode and the BrLite local output port.

Parameters:
- BR_TXQ_DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(BR_TXQ_DEPTH)+1, occupancy counter width (localparam, derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- cfg_en_i  in  1  MMR access strobe.
- cfg_we_i  in  1  MMR write enable.
- cfg_addr_i  in  brq_mmr_t  MMR select.
- cfg_data_i  in  32  MMR write data.
- cfg_data_o  out  32  MMR read data; combinational.
- irq_o  out  1  interrupt to CPU.
- br_local_busy_i  in  1  router local port busy.
- br_req_o  out  1  send request.
- br_ack_i  in  1  router accepted the head message.
- br_data_o  out  brlite_out_t  head message; stable while br_req_o=1.

Behaviour:
- Reset values: br_req_o=0, br_data_o='0, irq_o=0, count=0, rd/wr pointers=0, staging regs=0, ovf=0, drained=0, irq_en=0, FSM=IDLE.
- Write = cfg_en_i&&cfg_we_i. Staging writes:
  - BRQ_SERVICE: service <= data[1:0]
  - BRQ_KSVC: ksvc <= data[7:0]
  - BRQ_TARGET: seq_target <= data[15:0]
  - BRQ_PRODUCER: producer <= data[15:0]
  - BRQ_PAYLOAD: payload <= data[31:0]
- Staging registers persist after push, so repeated pushes resend the same message.
- BRQ_PUSH write with data[0]=1:
  - If not full: enqueue the staging snapshot at wr_ptr, increment wr_ptr (wraps mod DEPTH).
  - If full: discard, set ovf. Full is evaluated before any same-cycle pop, so a push on full is always rejected.
- Pop happens when br_req_o && br_ack_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- br_data_o is combinationally driven from mem[rd_ptr].
- FSM:
  - IDLE: if !empty && !br_local_busy_i, go to REQ. br_req_o is registered and rises on entry, 1 cycle after the condition.
  - REQ: br_req_o=1. On br_ack_i: pop, drop br_req_o, go to GAP.
  - GAP: exactly one cycle with br_req_o=0, then IDLE. Back-to-back messages are therefore spaced at least 2 cycles apart.
  - br_local_busy_i is sampled only in IDLE. Once in REQ, the request is held until ack.
- Drained flag: set when a pop takes count from 1 to 0 with no same-cycle push.
- BRQ_IRQ_STATUS write is W1C: bit0 clears drained, bit1 clears ovf. A same-cycle set has priority over the clear.
- BRQ_IRQ_EN write: irq_en <= data[1:0].
- irq_o = (irq_en[0]&drained) | (irq_en[1]&ovf); combinational from registers.
- BRQ_FLUSH write with data[0]=1:
  - In IDLE or GAP: count <= 0, wr_ptr <= rd_ptr.
  - In REQ: the in-flight head is kept (count <= 1, wr_ptr <= rd_ptr+1) and completes normally.
  - A push in the same cycle as a flush is ignored.
  - Flush does not set drained.
- Read map (unlisted addresses return 0):
  - BRQ_STATUS = {count zero-extended in [15:8], [7:4]=0, state[3:2], full[1], empty[0]}.
  - BRQ_IRQ_STATUS = {30'b0, ovf, drained}.
  - BRQ_IRQ_EN = {30'b0, irq_en}.
  - BRQ_DEPTH = 32'(BR_TXQ_DEPTH).
- Reset mid-handshake: everything returns to reset values next edge; br_req_o drops, the in-flight message is lost.

Decomposition:
- Shared package DMNIPkg:
  - brq_mmr_t enum: BRQ_SERVICE, BRQ_KSVC, BRQ_TARGET, BRQ_PRODUCER, BRQ_PAYLOAD, BRQ_PUSH, BRQ_FLUSH, BRQ_STATUS, BRQ_IRQ_STATUS, BRQ_IRQ_EN, BRQ_DEPTH.
  - brq_state_t enum: IDLE=0, REQ=1, GAP=2.
  - brlite_out_t is reused unchanged.
- One sub-module: brq_fifo.
  - Storage array, pointers, count, full/empty.
  - Push/pop/flush-keep-head inputs.
- The top level holds staging regs, FSM, IRQ flags and the read mux.

Test Plan:
- Single message: stage ksvc=8'h21, target=16'h0102, producer=16'h0304, payload=32'hDEADBEEF, push → br_req_o rises 1 cycle later with those fields; ack → req low, STATUS empty=1, drained=1; irq_o=1 only if irq_en[0]=1.
- Fill and overflow, DEPTH=4: 5 pushes with payloads 1..5, br_local_busy_i=1 → count=4, full=1, ovf=1; release busy → payloads 1,2,3,4 emitted in order, each separated by ≥1 req-low cycle.
- Simultaneous: count=4 in REQ, push and ack in same cycle → push rejected, ovf=1, count=3. At count=2, push+ack → count stays 2.
- Flush during REQ with count=3 → count=1; the head is still acked and emitted; afterwards empty=1 and no further req.
- W1C race: write IRQ_STATUS=1 in the cycle a pop empties the queue → drained stays 1. A later write of 1 clears it and irq_o falls.
- Reset asserted while br_req_o=1 → next cycle br_req_o=0, count=0, STATUS=32'h1.
